// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port (i)
// and a load/store port (d). At most one transaction is outstanding; a new
// grant can be issued in the same cycle the previous response returns.
//
// Optional feature, enabled by defining MEM_ARBITER_FAIR_EN: a 4-bit
// starvation counter. It lets a waiting fetch win after STARVE_LIMIT
// consecutive data grants. Without the macro, data always has priority.
//
// state  | meaning
// IDLE   | no transaction outstanding
// I_BUSY | fetch accepted by memory, waiting for its response
// D_BUSY | load/store accepted by memory, waiting for its response
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic free;
  logic sel_d;
  logic accept;
  logic starved;

  // The arbiter can issue a new request when idle or when the current
  // response is returning this cycle.
  assign free   = (state == IDLE) || m_rvalid;
  // Data wins unless it is absent or the fetch is starved; an absent fetch
  // also defaults the mux to the data side.
  assign sel_d  = (d_req && !starved) || !i_req;
  assign accept = m_req && m_gnt;

`ifdef MEM_ARBITER_FAIR_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  // Count data grants that bypass a waiting fetch; saturate at LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (!i_req || (accept && !sel_d)) begin
      cnt <= 4'd0;
    end else if (accept && sel_d && (cnt != LIMIT)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign starved = (cnt == LIMIT);
`else
  assign starved = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: stay busy until the response, then either take the
  // next grant or fall back to IDLE.
  always_comb begin
    state_nxt = state;
    if (free) begin
      if (accept) begin
        state_nxt = sel_d ? D_BUSY : I_BUSY;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Outputs: request mux, grants and response routing, all forced low in reset.
  always_comb begin
    m_req    = !reset && free && (i_req || d_req);
    m_we     = 1'b0;
    m_be     = 4'b1111;
    m_addr   = i_addr;
    m_wdata  = 32'd0;
    if (sel_d) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
    i_gnt    = accept && !sel_d;
    d_gnt    = accept && sel_d;
    i_rvalid = !reset && (state == I_BUSY) && m_rvalid;
    d_rvalid = !reset && (state == D_BUSY) && m_rvalid;
    i_rdata  = m_rdata;
    d_rdata  = m_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A behavioural memory answers accepted requests one
// cycle later with data derived from the address; grants push the expected
// response onto a queue and response strobes pop and compare it.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        mem_en;
  logic        mem_rv;
  logic [31:0] mem_rd;
  logic        inj_rv;
  logic [31:0] inj_data;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  logic glog[$];
  int   rv_cnt;
  int   checks;
  int   failures;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  assign m_rvalid = mem_rv | inj_rv;
  assign m_rdata  = inj_rv ? inj_data : mem_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: accept at the sampled request, respond the next cycle.
  always begin : mem_model
    logic        acc;
    logic [31:0] acc_data;
    @(negedge clk);
    acc      = m_req && m_gnt && mem_en;
    acc_data = mem_f(m_addr);
    @(posedge clk);
    #1;
    mem_rv = acc;
    mem_rd = acc_data;
  end

  // Scoreboard monitor: responses pop first, then this cycle's grant pushes.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_rvalid || d_rvalid) begin
        exp_t e;
        rv_cnt++;
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("rv_port", {31'd0, d_rvalid}, {31'd0, e.port});
          chk("rv_data", d_rvalid ? d_rdata : i_rdata, e.data);
        end
      end
      if (i_gnt || d_gnt) begin
        chk("gnt_onehot", {31'd0, i_gnt & d_gnt}, 0);
      end
      if (i_gnt) begin
        sb.push_back('{1'b0, mem_f(i_addr)});
        glog.push_back(1'b0);
      end
      if (d_gnt) begin
        sb.push_back('{1'b1, mem_f(d_addr)});
        glog.push_back(1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d;
    checks = 0; failures = 0; rv_cnt = 0;
    mem_rv = 1'b0; mem_rd = 32'd0;
    reset = 1'b1; mem_en = 1'b1; m_gnt = 1'b1;
    inj_rv = 1'b1; inj_data = 32'h0BAD_0BAD;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

    // reset holds every control output low even with requests and a response present
    @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    tick();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; inj_rv = 1'b0;
    @(negedge clk);
    chk("idle_m_req", m_req, 0);

    // single fetch, 1-cycle latency
    tick();
    i_req = 1'b1; i_addr = 32'h0; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("f_i_gnt", i_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_m_addr", m_addr, 32'h0);
    chk("f_m_we", m_we, 0);
    chk("f_m_be", m_be, 32'hF);
    chk("f_m_wdata", m_wdata, 0);
    tick();
    i_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("f_i_rvalid", i_rvalid, 1);
    chk("f_i_rdata", i_rdata, mem_f(32'h0));
    tick();

    // contention with a store: data first, fetch granted with the ack
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_be = 4'b0011; d_wdata = 32'h1234_ABCD;
    @(negedge clk);
    chk("c_d_gnt", d_gnt, 1);
    chk("c_i_gnt", i_gnt, 0);
    chk("c_m_we", m_we, 1);
    chk("c_m_be", m_be, 32'h3);
    chk("c_m_addr", m_addr, 32'h400);
    chk("c_m_wdata", m_wdata, 32'h1234_ABCD);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("c_d_rvalid", d_rvalid, 1);
    chk("c_i_rvalid0", i_rvalid, 0);
    chk("c_i_gnt2", i_gnt, 1);
    chk("c_m_addr2", m_addr, 32'h100);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("c_i_rvalid", i_rvalid, 1);
    tick();

    // memory stalls three cycles; the fetch request must hold steady
    m_gnt = 1'b0; i_req = 1'b1; i_addr = 32'h200; d_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s_m_req", m_req, 1);
      chk("s_m_addr", m_addr, 32'h200);
      chk("s_m_we", m_we, 0);
      chk("s_i_gnt", i_gnt, 0);
      tick();
    end
    m_gnt = 1'b1;
    @(negedge clk);
    chk("s_i_gnt4", i_gnt, 1);
    tick();
    i_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("s_i_rvalid", i_rvalid, 1);
    tick();

    // zero-wait streaming: 8 fetches complete within 9 cycles
    rv_cnt = 0;
    glog.delete();
    for (int k = 0; k < 8; k++) begin
      i_req = 1'b1; i_addr = 32'h1000 + 32'(4 * k);
      @(negedge clk);
      tick();
    end
    i_req = 1'b0;
    @(negedge clk);
    tick();
    chk("z_rvalid_cnt", rv_cnt, 8);
    chk("z_gnt_cnt", glog.size(), 8);

    // both requesters held high for ten grants
    glog.delete();
    i_req = 1'b1; i_addr = 32'h2000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
    repeat (10) begin
      @(negedge clk);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    tick();
    chk("o_gnt_cnt", glog.size(), 10);
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARBITER_FAIR_EN
      exp_d = ((k % (LIMIT + 1)) != LIMIT);
`else
      exp_d = 1'b1;
`endif
      if (k < glog.size()) chk($sformatf("o_order%0d", k), {31'd0, glog[k]}, {31'd0, exp_d});
    end

    // reset while a load is outstanding; the late response must be dropped
    mem_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    @(negedge clk);
    chk("r_d_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0; reset = 1'b1; inj_rv = 1'b1; inj_data = 32'hCAFE_F00D;
    @(negedge clk);
    chk("r_rst_d_rvalid", d_rvalid, 0);
    chk("r_rst_m_req", m_req, 0);
    tick();
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("r_late_d_rvalid", d_rvalid, 0);
    chk("r_late_i_rvalid", i_rvalid, 0);
    tick();
    inj_rv = 1'b0; mem_en = 1'b1; i_req = 1'b1; i_addr = 32'h40;
    @(negedge clk);
    chk("r_idle_m_req", m_req, 1);
    chk("r_idle_i_gnt", i_gnt, 1);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("r_i_rvalid", i_rvalid, 1);
    tick();

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
